// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with mid-bit sampling, start-glitch rejection,
// parity/frame error reporting and a one-cycle valid strobe.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_Pclk,
  input  logic                 i_Rst_n,
  input  logic                 i_Enable,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          clk_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr, fe, fin, rx_s, tick;
  assign rx_s   = sync[SYNC_STAGES-1];
  assign tick   = clk_cnt == LAST;
  assign o_Busy = state != S_IDLE;
  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      state        <= S_IDLE;
      sync         <= '1;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      fe           <= 1'b0;
      fin          <= 1'b0;
      o_Data       <= '0;
      o_Valid      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], i_Rx_Serial};
      o_Valid <= 1'b0;
      case (state)
        S_IDLE: if (i_Enable && !rx_s) begin
          clk_cnt <= '0;
          state   <= S_START;
        end
        S_START: if (clk_cnt == HALF) begin
          // a line that is high again at half-bit was only a glitch
          clk_cnt <= '0;
          bit_cnt <= '0;
          perr    <= 1'b0;
          fe      <= 1'b0;
          fin     <= 1'b0;
          state   <= rx_s ? S_IDLE : S_DATA;
        end else clk_cnt <= clk_cnt + 1'b1;
        S_DATA: if (tick) begin
          clk_cnt <= '0;
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt == DLAST ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == DLAST) state <= PARITY != 0 ? S_PAR : S_STOP;
        end else clk_cnt <= clk_cnt + 1'b1;
        S_PAR: if (tick) begin
          clk_cnt <= '0;
          perr    <= PARITY == 1 ? ~^{shreg, rx_s} : ^{shreg, rx_s};
          state   <= S_STOP;
        end else clk_cnt <= clk_cnt + 1'b1;
        S_STOP: if (fin) begin
          o_Data       <= shreg;
          o_Valid      <= 1'b1;
          o_Parity_Err <= perr;
          o_Frame_Err  <= fe;
          state        <= fe ? S_BREAK : S_IDLE;
        end else if (tick) begin
          clk_cnt <= '0;
          fe      <= fe | ~rx_s;
          fin     <= bit_cnt == SLAST;
          bit_cnt <= bit_cnt + 1'b1;
        end else clk_cnt <= clk_cnt + 1'b1;
        S_BREAK: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
